// File: rtl/sub_writeback.sv
// -----------------------------------------------------------------------------
// sub_writeback
//
// Purpose:
//   Collects the column elements produced by the subtract stage. Each column
//   arrives as 1 to 3 words. The words are held in a staging buffer and
//   copied as one unit into a 3x3 word array (mem[col][row]) during a
//   single COMMIT cycle. The array can be read at any time through a
//   registered read port. Staging contents never appear on the read port
//   before the commit.
//
// Optional feature:
//   SUB_WB_NORM_EN - when defined, adds the norm_sq output. norm_sq holds
//   the sum of the signed squares of the last committed column.
//
// Ports:
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous active-high reset
//   start_w  in   1   write strobe; qualifies sub_o
//   sub_o    in   16  column element
//   stop     in   1   current word is the last of the column
//   col_sel  in   2   target column (0..2), sampled with the first word
//   ready    out  1   a word can be accepted this cycle
//   done     out  1   one-cycle pulse while the column commits
//   short    out  1   sticky; a column ended with fewer than 3 words
//   ovf      out  1   sticky; word offered while not ready, or col_sel=3
//   rd_col   in   2   read column index
//   rd_row   in   2   read row index
//   rd_data  out  16  registered read data (0 for index 3)
//   norm_sq  out  32  sum of squares of last committed column (macro only)
// -----------------------------------------------------------------------------
module sub_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_w,
    input  logic [15:0] sub_o,
    input  logic        stop,
    input  logic [1:0]  col_sel,
    output logic        ready,
    output logic        done,
    output logic        short,
    output logic        ovf,
    input  logic [1:0]  rd_col,
    input  logic [1:0]  rd_row,
    output logic [15:0] rd_data
`ifdef SUB_WB_NORM_EN
    ,
    output logic [31:0] norm_sq
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [1:0] BAD_COL = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        accept_s;
    logic [1:0]  col_r;
    logic [1:0]  row_r;
    logic [15:0] stage_r [0:2];
    logic [15:0] mem_r   [0:2][0:2];
    logic        ready_r;
    logic        done_r;
    logic        short_r;
    logic        ovf_r;
    logic [15:0] rd_data_r;

    // ready_r is kept equal to (state_r != COMMIT), so it qualifies acceptance
    assign accept_s = start_w & ready_r;

    // Next-state selection for the collect/commit FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (stop) begin
                        state_nxt_s = COMMIT;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                // row_r==2 means this word fills the last row
                if (accept_s && (stop || (row_r == 2'd2))) begin
                    state_nxt_s = COMMIT;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            COMMIT: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, registered status outputs, staging buffer and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            short_r    <= 1'b0;
            ovf_r      <= 1'b0;
            col_r      <= 2'd0;
            row_r      <= 2'd0;
            stage_r[0] <= 16'd0;
            stage_r[1] <= 16'd0;
            stage_r[2] <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            // ready and done are registered images of the next state
            ready_r <= (state_nxt_s != COMMIT);
            done_r  <= (state_nxt_s == COMMIT);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        col_r      <= col_sel;
                        // later rows are pre-cleared so unwritten rows commit as 0
                        stage_r[0] <= sub_o;
                        stage_r[1] <= 16'd0;
                        stage_r[2] <= 16'd0;
                        row_r      <= 2'd1;
                        if (col_sel == BAD_COL) begin
                            ovf_r <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (accept_s) begin
                        stage_r[row_r] <= sub_o;
                        row_r          <= row_r + 2'd1;
                    end
                end
                COMMIT: begin
                    // row_r holds the number of words received in this column
                    if (row_r != 2'd3) begin
                        short_r <= 1'b1;
                    end
                    // a word offered while not ready is dropped and flagged
                    if (start_w) begin
                        ovf_r <= 1'b1;
                    end
                    row_r <= 2'd0;
                end
                default: begin
                    row_r <= 2'd0;
                end
            endcase
        end
    end

    // Column array: written only at the end of the COMMIT cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    mem_r[c][r] <= 16'd0;
                end
            end
        end else begin
            if ((state_r == COMMIT) && (col_r != BAD_COL)) begin
                for (int r = 0; r < 3; r++) begin
                    mem_r[col_r][r] <= stage_r[r];
                end
            end
        end
    end

    // Registered read port; the same edge as the commit still returns old data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_r <= 16'd0;
        end else begin
            if ((rd_col == 2'd3) || (rd_row == 2'd3)) begin
                rd_data_r <= 16'd0;
            end else begin
                rd_data_r <= mem_r[rd_col][rd_row];
            end
        end
    end

    assign ready   = ready_r;
    assign done    = done_r;
    assign short   = short_r;
    assign ovf     = ovf_r;
    assign rd_data = rd_data_r;

`ifdef SUB_WB_NORM_EN
    logic signed [31:0] sq_s;
    logic        [31:0] acc_r;
    logic        [31:0] norm_r;

    // Both operands are sign-extended to 32 bits, so the product is the signed square
    assign sq_s = $signed(sub_o) * $signed(sub_o);

    // Square accumulator, restarted by the first word of each column
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r  <= 32'd0;
            norm_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        acc_r <= sq_s;
                    end
                end
                FILL: begin
                    if (accept_s) begin
                        acc_r <= acc_r + sq_s;
                    end
                end
                COMMIT: begin
                    // a discarded column leaves the last norm untouched
                    if (col_r != BAD_COL) begin
                        norm_r <= acc_r;
                    end
                end
                default: begin
                    acc_r <= 32'd0;
                end
            endcase
        end
    end

    assign norm_sq = norm_r;
`endif

endmodule

// File: tb/tb_sub_writeback.sv
module tb_sub_writeback;

    logic        clk;
    logic        reset;
    logic        start_w;
    logic [15:0] sub_o;
    logic        stop;
    logic [1:0]  col_sel;
    logic        ready;
    logic        done;
    logic        short;
    logic        ovf;
    logic [1:0]  rd_col;
    logic [1:0]  rd_row;
    logic [15:0] rd_data;
`ifdef SUB_WB_NORM_EN
    logic [31:0] norm_sq;
`endif

    sub_writeback dut (
        .clk     (clk),
        .reset   (reset),
        .start_w (start_w),
        .sub_o   (sub_o),
        .stop    (stop),
        .col_sel (col_sel),
        .ready   (ready),
        .done    (done),
        .short   (short),
        .ovf     (ovf),
        .rd_col  (rd_col),
        .rd_row  (rd_row),
        .rd_data (rd_data)
`ifdef SUB_WB_NORM_EN
        ,
        .norm_sq (norm_sq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               col;
        logic [2:0][15:0] d;
        bit               shrt;
        logic [31:0]      nsq;
    } col_t;

    col_t        sb_q [$];
    logic [15:0] exp_mem [0:2][0:2];
    bit          short_m;
    bit          ovf_m;
    logic [31:0] norm_m;
    int          n_cmp;
    int          n_err;
    int          waited;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                exp_mem[c][r] = 16'd0;
            end
        end
        short_m = 1'b0;
        ovf_m   = 1'b0;
        norm_m  = 32'd0;
    endtask

    // Builds the expected outcome of one column and queues it for checking
    task automatic push_col(input int col, input int n, input logic [15:0] w0,
                            input logic [15:0] w1, input logic [15:0] w2);
        col_t e;
        logic [15:0] w [3];
        logic signed [31:0] s;
        w[0] = w0; w[1] = w1; w[2] = w2;
        e.col  = col;
        e.shrt = (n < 3);
        e.nsq  = 32'd0;
        for (int r = 0; r < 3; r++) begin
            if (r < n) begin
                e.d[r] = w[r];
                s = $signed(w[r]);
                e.nsq = e.nsq + s * s;
            end else begin
                e.d[r] = 16'd0;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [15:0] w, input logic s, input logic [1:0] c);
        start_w = 1'b1;
        sub_o   = w;
        stop    = s;
        col_sel = c;
        @(posedge clk);
        #1;
        start_w = 1'b0;
        stop    = 1'b0;
    endtask

    task automatic read_all();
        logic [15:0] e;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd_col = c[1:0];
                rd_row = r[1:0];
                @(posedge clk);
                #1;
                e = (c == 3 || r == 3) ? 16'd0 : exp_mem[c][r];
                check_eq($sformatf("mem[%0d][%0d]", c, r), {16'd0, rd_data}, {16'd0, e});
            end
        end
    endtask

    // Waits for done, pops the expected column and checks commit effects
    task automatic wait_done(output int w);
        col_t e;
        logic [15:0] old;
        w = 0;
        while (!done && w < 8) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!done) begin
            check_eq("done_timeout", 32'd0, 32'd1);
            start_w = 1'b0;
            return;
        end
        check_eq("ready_in_commit", {31'd0, ready}, 32'd0);
        if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_done", 32'd1, 32'd0);
            start_w = 1'b0;
            return;
        end
        e = sb_q.pop_front();
        rd_col = e.col[1:0];
        rd_row = 2'd0;
        old = (e.col == 3) ? 16'd0 : exp_mem[e.col][0];
        @(posedge clk);
        #1;
        start_w = 1'b0;
        check_eq("commit_old_read", {16'd0, rd_data}, {16'd0, old});
        check_eq("done_pulse", {31'd0, done}, 32'd0);
        if (e.col != 3) begin
            for (int r = 0; r < 3; r++) begin
                exp_mem[e.col][r] = e.d[r];
            end
            norm_m = e.nsq;
        end else begin
            ovf_m = 1'b1;
        end
        if (e.shrt) short_m = 1'b1;
        check_eq("short", {31'd0, short}, {31'd0, short_m});
        check_eq("ovf", {31'd0, ovf}, {31'd0, ovf_m});
`ifdef SUB_WB_NORM_EN
        check_eq("norm_sq", norm_sq, norm_m);
`endif
        read_all();
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        start_w = 1'b0;
        sub_o   = 16'd0;
        stop    = 1'b0;
        col_sel = 2'd0;
        rd_col  = 2'd0;
        rd_row  = 2'd0;
        clear_model();

        // Reset state
        #12;
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_short", {31'd0, short}, 32'd0);
        check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
        check_eq("rst_rd_data", {16'd0, rd_data}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Full column, first word on the first edge after reset
        push_col(1, 3, 16'h0003, 16'hFFFE, 16'h0005);
        send(16'h0003, 1'b0, 2'd1);
        send(16'hFFFE, 1'b0, 2'd1);
        send(16'h0005, 1'b1, 2'd1);
        wait_done(waited);
        check_eq("full_latency", waited, 32'd0);

        // Short column
        push_col(0, 2, 16'h0007, 16'h0009, 16'h0000);
        send(16'h0007, 1'b0, 2'd0);
        send(16'h0009, 1'b1, 2'd0);
        wait_done(waited);
        check_eq("short_latency", waited, 32'd0);

        // Gapped input; stray stop in a gap; staging not visible on reads
        push_col(2, 3, 16'h0011, 16'h8022, 16'h0033);
        rd_col = 2'd2;
        rd_row = 2'd0;
        send(16'h0011, 1'b0, 2'd2);
        for (int g = 0; g < 2; g++) begin
            stop = (g == 0);
            check_eq("gap_no_done", {31'd0, done}, 32'd0);
            @(posedge clk);
            #1;
            stop = 1'b0;
            check_eq("gap_no_done", {31'd0, done}, 32'd0);
            check_eq("gap_no_stage_read", {16'd0, rd_data}, {16'd0, exp_mem[2][0]});
            @(posedge clk);
            #1;
            send((g == 0) ? 16'h8022 : 16'h0033, 1'b0, 2'd2);
        end
        wait_done(waited);
        check_eq("gap_latency", waited, 32'd0);

        // Invalid column
        push_col(3, 3, 16'h1111, 16'h2222, 16'h3333);
        send(16'h1111, 1'b0, 2'd3);
        send(16'h2222, 1'b0, 2'd3);
        send(16'h3333, 1'b0, 2'd3);
        wait_done(waited);
        check_eq("bad_col_latency", waited, 32'd0);

        // Mid-FILL reset
        rd_col = 2'd1;
        rd_row = 2'd0;
        send(16'h0AAA, 1'b0, 2'd2);
        send(16'h0BBB, 1'b0, 2'd2);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_ready", {31'd0, ready}, 32'd1);
        check_eq("mid_rst_done", {31'd0, done}, 32'd0);
        check_eq("mid_rst_short", {31'd0, short}, 32'd0);
        check_eq("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        check_eq("mid_rst_rd_data", {16'd0, rd_data}, 32'd0);
`ifdef SUB_WB_NORM_EN
        check_eq("mid_rst_norm", norm_sq, 32'd0);
`endif
        clear_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_col(2, 3, 16'h0101, 16'h0202, 16'hFF03);
        send(16'h0101, 1'b0, 2'd2);
        send(16'h0202, 1'b0, 2'd2);
        send(16'hFF03, 1'b0, 2'd2);
        wait_done(waited);
        check_eq("post_rst_latency", waited, 32'd0);

        // Overflow: start_w held into COMMIT, fourth word dropped
        push_col(0, 3, 16'h0004, 16'h0005, 16'h0006);
        start_w = 1'b1;
        stop    = 1'b0;
        col_sel = 2'd0;
        sub_o   = 16'h0004;
        @(posedge clk);
        #1;
        sub_o = 16'h0005;
        @(posedge clk);
        #1;
        sub_o = 16'h0006;
        @(posedge clk);
        #1;
        check_eq("ovf_pre", {31'd0, ovf}, 32'd0);
        sub_o = 16'hDEAD;
        ovf_m = 1'b1;
        wait_done(waited);
        check_eq("ovf_latency", waited, 32'd0);
        check_eq("ovf_no_new_col", {31'd0, done}, 32'd0);
        check_eq("ovf_ready", {31'd0, ready}, 32'd1);

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sub_writeback.md
SUB_WRITEBACK -- requirements
Module: sub_writeback

Interface
REQ-001 SHALL have a single clock `clk`; `reset` is asynchronous and active-high.
REQ-002 Ports, clock and reset first:
  - clk      in   1   rising-edge clock
  - reset    in   1   async active-high reset
  - start_w  in   1   write strobe from the subtract stage; qualifies sub_o
  - sub_o    in   16  column element from the subtract stage
  - stop     in   1   producer marks the current word as the last of the column
  - col_sel  in   2   target column 0..2, sampled with the first word
  - ready    out  1   block can accept a word this cycle
  - done     out  1   one-cycle pulse; column committed
  - short    out  1   sticky; a column ended before 3 words
  - ovf      out  1   sticky; start_w seen while not ready, or col_sel=3
  - rd_col   in   2   read column index
  - rd_row   in   2   read row index
  - rd_data  out  16  registered read data
  - norm_sq  out  32  sum of squares of last committed column; present only with the macro

Function
REQ-003 SHALL store a 3x3 array of 16-bit words (mem[col][row]); all entries are 0 after reset.
REQ-004 A word SHALL be accepted on a rising edge where start_w=1 and ready=1.
REQ-005 FSM states SHALL be IDLE, FILL and COMMIT; ready=1 in IDLE and FILL, and ready=0 in COMMIT.
REQ-006 IDLE behaviour on an accepted word:
  - latch col_sel into an internal column register;
  - write sub_o to row 0 of a 3-word staging buffer;
  - set the row counter to 1;
  - go to FILL, or go directly to COMMIT if stop=1.
REQ-007 FILL behaviour on an accepted word:
  - write sub_o to staging[row];
  - increment row;
  - go to COMMIT when row was 2 or stop=1.
REQ-008 FILL SHALL hold its state with no counter change on cycles where start_w=0; there is no timeout.
REQ-009 In COMMIT (exactly 1 cycle), the staging buffer SHALL be copied to mem[col]:
  - rows never written in this column are written as 0;
  - short is set if fewer than 3 words arrived;
  - done=1 for that cycle;
  - the next state is IDLE.
REQ-010 If col_sel=3 on the first word, ovf SHALL be set, the column SHALL be discarded (no mem write), and done SHALL still pulse.
REQ-011 start_w=1 during COMMIT SHALL set ovf and drop the word; mem and FSM are unaffected.
REQ-012 stop without start_w SHALL be ignored.
REQ-013 rd_data SHALL equal mem[rd_col][rd_row] one cycle after the address is presented; rd_row=3 or rd_col=3 returns 0.
REQ-014 A read of the column being committed in the COMMIT cycle SHALL return the old contents; new contents are visible from the next read.
REQ-015 Staging data SHALL NOT be visible on rd_data before COMMIT.
REQ-016 short and ovf SHALL clear only on reset.

Reset
REQ-017 On reset assertion, regardless of clk, the block SHALL immediately:
  - enter IDLE;
  - set ready=1 after reset, done=0, short=0, ovf=0, rd_data=0, norm_sq=0;
  - clear mem, staging, row and column registers.
REQ-018 Reset mid-FILL SHALL discard the partial column without writing mem.
REQ-019 The first word SHALL be accepted on the first clk edge after reset deasserts.

Configuration
REQ-020 Macro SUB_WB_NORM_EN SHALL control the norm_sq feature.
REQ-021 With SUB_WB_NORM_EN defined:
  - each accepted word adds the signed sub_o*sub_o (32-bit, wrap on overflow) to an accumulator that is cleared on entry to FILL from IDLE;
  - in COMMIT, norm_sq loads the accumulator value, then holds until the next COMMIT;
  - a discarded column (col_sel=3) does not update norm_sq.
REQ-022 Without SUB_WB_NORM_EN, the norm_sq port, multiplier and accumulator SHALL be absent; all other behaviour is identical.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - Full column: col_sel=1; words 0x0003, 0xFFFE, 0x0005 on consecutive cycles with stop on the 3rd -> done 1 cycle after the 3rd word; mem[1]={3,-2,5}; norm_sq=38 (macro on).
  - Short column: col_sel=0; words 0x0007, 0x0009 with stop on the 2nd -> done; mem[0]={7,9,0}; short=1.
  - Gapped input: col_sel=2; 3 words with 2 idle cycles between each -> mem[2] correct; done only after the 3rd word.
  - Overflow: start_w held high into COMMIT -> 4th word dropped; ovf=1; mem unchanged except the target column.
  - Invalid column: col_sel=3; 3 words -> done pulses; ovf=1; no mem change.
  - Mid-FILL reset: assert reset after 2 words -> all outputs are at reset values immediately; a following full column commits correctly.
